// File: rtl/write_fence_ctrl.sv
// rtl/write_fence_ctrl.sv - AXI write-path fence: tracks outstanding writes, drains them with SLVERR,
// then resets the slave and clears the write guard.
package write_fence_pkg;
  typedef logic [3:0] id_t;

  typedef struct packed {
    id_t         id;
    logic [31:0] addr;
    logic [7:0]  len;
  } aw_chan_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } w_chan_t;

  typedef struct packed {
    id_t        id;
    logic [1:0] resp;
  } b_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
  } req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    w_ready;
    b_chan_t b;
    logic    b_valid;
  } rsp_t;
endpackage

module write_fence_ctrl #(
  parameter int unsigned MaxWrTxns  = 8,
  parameter int unsigned CntWidth   = 16,
  parameter int unsigned HoldCycles = 16,
  parameter type         req_t      = write_fence_pkg::req_t,
  parameter type         rsp_t      = write_fence_pkg::rsp_t,
  parameter type         id_t       = write_fence_pkg::id_t
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  req_t mst_req_i,
  output rsp_t mst_rsp_o,
  output req_t slv_req_o,
  input  rsp_t slv_rsp_i,
  output logic wr_en_o,
  input  logic reset_req_i,
  output logic reset_clear_o,
  output logic slv_rst_no,
  output logic busy_o
);

  localparam int unsigned IdxW  = (MaxWrTxns > 1) ? $clog2(MaxWrTxns) : 1;
  localparam int unsigned HoldW = (HoldCycles > 1) ? $clog2(HoldCycles) : 1;
  localparam int unsigned CntW1 = CntWidth + 1;

  typedef enum logic [1:0] {IDLE, ABORT, SLV_RST, CLEAR} state_e;

  state_e               state_q, state_d;
  logic [MaxWrTxns-1:0] valid_q, valid_d;
  id_t                  ids_q [MaxWrTxns];
  id_t                  ids_d [MaxWrTxns];
  logic [CntWidth-1:0]  cnt_q, cnt_d;
  logic [HoldW-1:0]     hold_q, hold_d;
  logic                 slv_rst_q;

  logic [IdxW-1:0] free_idx, match_idx, err_idx, free_sel;
  logic            match_found, full, any_valid;
  logic            aw_hs, w_hs, free_en;

  assign full      = &valid_q;
  assign any_valid = |valid_q;

  // Lowest-index searches: free slot for AW, matching slot for slave B, oldest slot for error B.
  always_comb begin
    free_idx    = '0;
    match_idx   = '0;
    err_idx     = '0;
    match_found = 1'b0;
    for (int i = MaxWrTxns - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx = IdxW'(i);
      if (valid_q[i]) err_idx = IdxW'(i);
      if (valid_q[i] && (ids_q[i] == slv_rsp_i.b.id)) begin
        match_found = 1'b1;
        match_idx   = IdxW'(i);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    slv_req_o = mst_req_i;
    mst_rsp_o = '0;
    aw_hs     = 1'b0;
    w_hs      = 1'b0;
    free_en   = 1'b0;
    free_sel  = err_idx;

    case (state_q)
      IDLE: begin
        mst_rsp_o          = slv_rsp_i;
        mst_rsp_o.aw_ready = slv_rsp_i.aw_ready && !full;
        slv_req_o.aw_valid = mst_req_i.aw_valid && !full;
        aw_hs              = mst_req_i.aw_valid && slv_rsp_i.aw_ready && !full;
        w_hs               = mst_req_i.w_valid && slv_rsp_i.w_ready;
        free_en            = slv_rsp_i.b_valid && mst_req_i.b_ready && match_found;
        free_sel           = match_idx;
        if (reset_req_i) state_d = ABORT;
      end
      ABORT: begin
        // Owed W beats are absorbed here; the slave never sees them.
        mst_rsp_o.w_ready = (cnt_q != '0);
        w_hs              = mst_req_i.w_valid && (cnt_q != '0);
        mst_rsp_o.b_valid = any_valid;
        mst_rsp_o.b.id    = ids_q[err_idx];
        mst_rsp_o.b.resp  = 2'b10;
        free_en           = any_valid && mst_req_i.b_ready;
        if (!any_valid && (cnt_q == '0)) begin
          state_d = SLV_RST;
          hold_d  = '0;
        end
      end
      SLV_RST: begin
        hold_d = hold_q + 1'b1;
        if (hold_q == HoldW'(HoldCycles - 1)) state_d = CLEAR;
      end
      CLEAR: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if ((state_q != IDLE) || !rst_ni) begin
      slv_req_o.aw_valid = 1'b0;
      slv_req_o.w_valid  = 1'b0;
      slv_req_o.b_ready  = 1'b0;
    end
    if (!rst_ni) mst_rsp_o = '0;
  end

  always_comb begin
    valid_d = valid_q;
    ids_d   = ids_q;
    cnt_d   = cnt_q;
    if (free_en) valid_d[free_sel] = 1'b0;
    if (aw_hs) begin
      valid_d[free_idx] = 1'b1;
      ids_d[free_idx]   = mst_req_i.aw.id;
      cnt_d             = cnt_d + CntWidth'(mst_req_i.aw.len) + CntWidth'(1);
    end
    if (w_hs) cnt_d = cnt_d - CntWidth'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      valid_q   <= '0;
      cnt_q     <= '0;
      hold_q    <= '0;
      slv_rst_q <= 1'b1;
      for (int i = 0; i < MaxWrTxns; i++) ids_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      ids_q     <= ids_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      slv_rst_q <= (state_d != SLV_RST);
    end
  end

  assign wr_en_o       = aw_hs && rst_ni;
  assign slv_rst_no    = slv_rst_q;
  assign busy_o        = (state_q != IDLE);
  assign reset_clear_o = (state_q == CLEAR);

  logic [CntW1-1:0] cnt_sum;
  assign cnt_sum = {1'b0, cnt_q} + CntW1'(mst_req_i.aw.len) + CntW1'(1);

  a_cnt_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    aw_hs |-> !cnt_sum[CntWidth]);
  a_cnt_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (w_hs && !aw_hs) |-> (cnt_q != '0));

endmodule

// File: tb/tb_write_fence_ctrl.sv
// tb/tb_write_fence_ctrl.sv - directed vector and sequence bench for write_fence_ctrl.
module tb_write_fence_ctrl;
  import write_fence_pkg::*;

  logic clk_i = 1'b0;
  logic rst_ni, reset_req_i, wr_en_o, reset_clear_o, slv_rst_no, busy_o;
  req_t mst_req, slv_req;
  rsp_t mst_rsp, slv_rsp;

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  write_fence_ctrl #(
    .MaxWrTxns(8), .CntWidth(16), .HoldCycles(16),
    .req_t(req_t), .rsp_t(rsp_t), .id_t(id_t)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .mst_req_i(mst_req), .mst_rsp_o(mst_rsp),
    .slv_req_o(slv_req), .slv_rsp_i(slv_rsp),
    .wr_en_o(wr_en_o), .reset_req_i(reset_req_i),
    .reset_clear_o(reset_clear_o), .slv_rst_no(slv_rst_no), .busy_o(busy_o)
  );

  typedef struct {
    logic       aw_v;
    logic [3:0] aw_id;
    logic [7:0] aw_len;
    logic       s_aw_rdy;
    logic       w_v;
    logic       s_w_rdy;
    logic       s_b_v;
    logic [3:0] b_id;
    logic       m_b_rdy;
    logic       e_aw_rdy;
    logic       e_s_aw_v;
    logic       e_wr_en;
    logic       e_w_rdy;
    logic       e_b_v;
    logic [3:0] e_b_id;
    logic       e_s_b_rdy;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n_acc, sunk, leak, n_busy, n_abort, n_rst, n_clr;
    logic found;
    logic [9:0] act, exp;
    int drain [8] = '{0, 1, 2, 4, 5, 6, 7, 9};

    vecs[0] = '{0, 4'd0, 8'd0, 1, 0, 0, 0, 4'd0, 0,  1, 0, 0, 0, 0, 4'd0, 0};
    vecs[1] = '{1, 4'd1, 8'd0, 1, 1, 1, 0, 4'd0, 0,  1, 1, 1, 1, 0, 4'd0, 0};
    vecs[2] = '{1, 4'd2, 8'd0, 1, 1, 1, 0, 4'd0, 0,  1, 1, 1, 1, 0, 4'd0, 0};
    vecs[3] = '{1, 4'd1, 8'd0, 1, 1, 1, 0, 4'd0, 0,  1, 1, 1, 1, 0, 4'd0, 0};
    vecs[4] = '{1, 4'd3, 8'd0, 0, 0, 0, 0, 4'd0, 0,  0, 1, 0, 0, 0, 4'd0, 0};
    vecs[5] = '{0, 4'd0, 8'd0, 1, 0, 0, 1, 4'd1, 1,  1, 0, 0, 0, 1, 4'd1, 1};
    vecs[6] = '{0, 4'd0, 8'd0, 1, 0, 0, 1, 4'd7, 0,  1, 0, 0, 0, 1, 4'd7, 0};
    vecs[7] = '{0, 4'd0, 8'd0, 1, 0, 0, 1, 4'd2, 1,  1, 0, 0, 0, 1, 4'd2, 1};
    vecs[8] = '{0, 4'd0, 8'd0, 1, 0, 0, 1, 4'd1, 1,  1, 0, 0, 0, 1, 4'd1, 1};

    // Reset state, with the slave offering ready so gating is visible.
    rst_ni = 1'b0;
    reset_req_i = 1'b0;
    mst_req = '0;
    slv_rsp = '0;
    slv_rsp.aw_ready = 1'b1;
    slv_rsp.w_ready = 1'b1;
    repeat (2) @(negedge clk_i);
    check("rst_slv_rst_no", slv_rst_no, 1);
    check("rst_busy", busy_o, 0);
    check("rst_clear", reset_clear_o, 0);
    check("rst_b_valid", mst_rsp.b_valid, 0);
    check("rst_aw_ready", mst_rsp.aw_ready, 0);
    check("rst_w_ready", mst_rsp.w_ready, 0);
    tick();
    rst_ni = 1'b1;
    slv_rsp.w_ready = 1'b0;

    // Pass-through vectors: three writes (ids 1,2,1) and their Bs, plus a stalled AW and stray B.
    for (int i = 0; i < 9; i++) begin
      mst_req.aw_valid = vecs[i].aw_v;
      mst_req.aw.id = vecs[i].aw_id;
      mst_req.aw.len = vecs[i].aw_len;
      slv_rsp.aw_ready = vecs[i].s_aw_rdy;
      mst_req.w_valid = vecs[i].w_v;
      slv_rsp.w_ready = vecs[i].s_w_rdy;
      slv_rsp.b_valid = vecs[i].s_b_v;
      slv_rsp.b.id = vecs[i].b_id;
      slv_rsp.b.resp = 2'b00;
      mst_req.b_ready = vecs[i].m_b_rdy;
      @(negedge clk_i);
      act = {mst_rsp.aw_ready, slv_req.aw_valid, wr_en_o, mst_rsp.w_ready,
             mst_rsp.b_valid, mst_rsp.b.id, slv_req.b_ready};
      exp = {vecs[i].e_aw_rdy, vecs[i].e_s_aw_v, vecs[i].e_wr_en, vecs[i].e_w_rdy,
             vecs[i].e_b_v, vecs[i].e_b_id, vecs[i].e_s_b_rdy};
      check($sformatf("vec%0d", i), 32'(act), 32'(exp));
      tick();
    end
    mst_req = '0;
    slv_rsp = '0;
    slv_rsp.aw_ready = 1'b1;

    // Fill all eight slots, then a ninth AW waits for a B.
    n_acc = 0;
    for (int i = 0; i < 8; i++) begin
      mst_req.aw_valid = 1'b1;
      mst_req.aw.id = 4'(i);
      mst_req.aw.len = 8'd0;
      mst_req.w_valid = 1'b1;
      slv_rsp.w_ready = 1'b1;
      @(negedge clk_i);
      if (wr_en_o) n_acc++;
      tick();
    end
    check("fill_accepts", n_acc, 8);
    mst_req.aw.id = 4'd9;
    mst_req.w_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      check("full_aw_ready", mst_rsp.aw_ready, 0);
      check("full_slv_aw_valid", slv_req.aw_valid, 0);
      check("full_wr_en", wr_en_o, 0);
      tick();
    end
    slv_rsp.b_valid = 1'b1;
    slv_rsp.b.id = 4'd3;
    mst_req.b_ready = 1'b1;
    @(negedge clk_i);
    check("full_free_cycle_aw_ready", mst_rsp.aw_ready, 0);
    tick();
    slv_rsp.b_valid = 1'b0;
    mst_req.w_valid = 1'b1;
    @(negedge clk_i);
    check("after_free_aw_ready", mst_rsp.aw_ready, 1);
    check("after_free_wr_en", wr_en_o, 1);
    tick();
    mst_req.aw_valid = 1'b0;
    mst_req.w_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      slv_rsp.b_valid = 1'b1;
      slv_rsp.b.id = 4'(drain[i]);
      tick();
    end
    slv_rsp.b_valid = 1'b0;
    mst_req.b_ready = 1'b0;
    slv_rsp.w_ready = 1'b0;

    // Fence with nothing outstanding: 1 ABORT + 16 SLV_RST + 1 CLEAR.
    reset_req_i = 1'b1;
    @(negedge clk_i);
    check("empty_busy_before", busy_o, 0);
    tick();
    reset_req_i = 1'b0;
    n_busy = 0; n_abort = 0; n_rst = 0; n_clr = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk_i);
      if (busy_o) n_busy++;
      if (busy_o && slv_rst_no && !reset_clear_o) n_abort++;
      if (!slv_rst_no) n_rst++;
      if (reset_clear_o) n_clr++;
      tick();
    end
    check("empty_busy_cycles", n_busy, 18);
    check("empty_abort_cycles", n_abort, 1);
    check("empty_rst_cycles", n_rst, 16);
    check("empty_clear_pulses", n_clr, 1);

    // Fence with two writes outstanding (id 4 len 3, id 5 len 0) and 3 W beats still owed.
    mst_req.aw_valid = 1'b1;
    mst_req.aw.id = 4'd4;
    mst_req.aw.len = 8'd3;
    tick();
    mst_req.aw.id = 4'd5;
    mst_req.aw.len = 8'd0;
    tick();
    mst_req.aw_valid = 1'b0;
    mst_req.w_valid = 1'b1;
    slv_rsp.w_ready = 1'b1;
    tick();
    tick();
    mst_req.w_valid = 1'b0;
    slv_rsp.w_ready = 1'b0;
    reset_req_i = 1'b1;
    @(negedge clk_i);
    check("fence_busy_before", busy_o, 0);
    tick();
    reset_req_i = 1'b0;
    mst_req.aw_valid = 1'b1;
    mst_req.aw.id = 4'd6;
    mst_req.w_valid = 1'b1;
    mst_req.b_ready = 1'b0;
    sunk = 0;
    leak = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_i);
      if (k == 0) check("fence_busy_latency", busy_o, 1);
      check("stall_b_valid", mst_rsp.b_valid, 1);
      check("stall_b_id", mst_rsp.b.id, 4);
      check("stall_b_resp", mst_rsp.b.resp, 2);
      if (mst_rsp.w_ready) sunk++;
      if (slv_req.w_valid || slv_req.aw_valid || wr_en_o || mst_rsp.aw_ready) leak++;
      tick();
    end
    check("fence_w_sunk", sunk, 3);
    check("fence_leaks", leak, 0);
    mst_req.aw_valid = 1'b0;
    mst_req.w_valid = 1'b0;
    mst_req.b_ready = 1'b1;
    @(negedge clk_i);
    check("err_b0", {mst_rsp.b_valid, mst_rsp.b.id, mst_rsp.b.resp}, {1'b1, 4'd4, 2'b10});
    tick();
    @(negedge clk_i);
    check("err_b1", {mst_rsp.b_valid, mst_rsp.b.id, mst_rsp.b.resp}, {1'b1, 4'd5, 2'b10});
    tick();
    @(negedge clk_i);
    check("err_b_done", mst_rsp.b_valid, 0);
    check("err_b_done_busy", busy_o, 1);
    mst_req.b_ready = 1'b0;
    n_rst = 0; n_clr = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      @(negedge clk_i);
      if (!slv_rst_no) n_rst++;
      if (reset_clear_o) n_clr++;
    end
    check("fence_rst_cycles", n_rst, 16);
    check("fence_clear_pulses", n_clr, 1);
    check("fence_idle_after", busy_o, 0);
    tick();

    // Guard still raised through CLEAR: one IDLE cycle, then ABORT again.
    reset_req_i = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_i);
      if (reset_clear_o) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("reraise_clear_seen", found, 1);
    tick();
    @(negedge clk_i);
    check("reraise_idle_gap", busy_o, 0);
    tick();
    reset_req_i = 1'b0;
    @(negedge clk_i);
    check("reraise_abort", busy_o, 1);
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_i);
      if (reset_clear_o) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("reraise_second_clear", found, 1);
    tick();

    // Async reset in the middle of SLV_RST.
    reset_req_i = 1'b1;
    tick();
    reset_req_i = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_i);
      if (!slv_rst_no) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("mid_rst_reached", found, 1);
    tick();
    tick();
    mst_req.aw_valid = 1'b1;
    slv_rsp.aw_ready = 1'b1;
    rst_ni = 1'b0;
    #1;
    check("async_slv_rst_no", slv_rst_no, 1);
    check("async_busy", busy_o, 0);
    check("async_clear", reset_clear_o, 0);
    check("async_aw_ready", mst_rsp.aw_ready, 0);
    check("async_slv_aw_valid", slv_req.aw_valid, 0);
    check("async_wr_en", wr_en_o, 0);
    tick();
    mst_req.aw_valid = 1'b0;
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("post_rst_busy", busy_o, 0);
    check("post_rst_slv_rst_no", slv_rst_no, 1);
    check("post_rst_aw_ready", mst_rsp.aw_ready, 1);
    repeat (3) tick();
    @(negedge clk_i);
    check("post_rst_still_idle", busy_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
